// File: rtl/seq_det_ctrl_if.sv
// Bus bundle for seq_det_ctrl: run request, pattern/window configuration,
// serial data in, and the status/result outputs.
interface seq_det_ctrl_if #(
  parameter int PAT_W = 8,
  parameter int CNT_W = 8
);
  localparam int LEN_W = $clog2(PAT_W) + 1;

  logic             start;
  logic [PAT_W-1:0] pattern;
  logic [LEN_W-1:0] pat_len;
  logic [CNT_W-1:0] window;
  logic             D;
  logic             busy;
  logic             match;
  logic             done;
  logic             err;
  logic [CNT_W-1:0] hit_cnt;

  modport master (
    output start, pattern, pat_len, window, D,
    input  busy, match, done, err, hit_cnt
  );

  modport slave (
    input  start, pattern, pat_len, window, D,
    output busy, match, done, err, hit_cnt
  );
endinterface

// File: rtl/seq_det_ctrl.sv
// Windowed serial pattern detector: counts occurrences of a programmable
// bit pattern over a fixed number of samples. Define SEQ_DET_OVERLAP_EN to allow overlapping matches.
module seq_det_ctrl #(
  parameter int PAT_W = 8,
  parameter int CNT_W = 8
) (
  input  logic          clk,
  input  logic          rst,
  seq_det_ctrl_if.slave bus
);
  localparam int LEN_W = $clog2(PAT_W) + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t           state;
  logic [PAT_W-1:0] pat_lat;
  logic [LEN_W-1:0] len_lat;
  logic [CNT_W-1:0] win_lat;
  logic [PAT_W-1:0] shreg;
  logic [LEN_W-1:0] seen;
  logic [CNT_W-1:0] samples;
  logic [CNT_W-1:0] hit_cnt;
  logic             busy;
  logic             match;
  logic             done;
  logic             err;

  logic [PAT_W-1:0] shift_nxt;
  logic [PAT_W-1:0] cmp_mask;
  logic [LEN_W-1:0] seen_nxt;
  logic [CNT_W-1:0] samples_nxt;
  logic [CNT_W-1:0] hit_nxt;
  logic             hit_now;
  logic             cfg_bad;

  function automatic logic [PAT_W-1:0] len_mask(input logic [LEN_W-1:0] len);
    logic [PAT_W-1:0] m;
    for (int i = 0; i < PAT_W; i++) begin
      m[i] = (i < int'(len));
    end
    return m;
  endfunction

  // Next-sample view of the shift register and the match decision on it.
  always_comb begin
    shift_nxt   = {shreg[PAT_W-2:0], bus.D};
    cmp_mask    = len_mask(len_lat);
    seen_nxt    = (seen == LEN_W'(PAT_W)) ? seen : seen + LEN_W'(1);
    samples_nxt = samples + CNT_W'(1);
    hit_nxt     = (hit_cnt == {CNT_W{1'b1}}) ? hit_cnt : hit_cnt + CNT_W'(1);
    hit_now     = (seen_nxt >= len_lat) &&
                  ((shift_nxt & cmp_mask) == (pat_lat & cmp_mask));
    cfg_bad     = (len_lat == LEN_W'(0)) || (len_lat > LEN_W'(PAT_W)) ||
                  (win_lat == CNT_W'(0));
  end

  // Control FSM with registered status outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      pat_lat <= '0;
      len_lat <= '0;
      win_lat <= '0;
      shreg   <= '0;
      seen    <= '0;
      samples <= '0;
      hit_cnt <= '0;
      busy    <= 1'b0;
      match   <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          match <= 1'b0;
          done  <= 1'b0;
          if (bus.start) begin
            pat_lat <= bus.pattern;
            len_lat <= bus.pat_len;
            win_lat <= bus.window;
            busy    <= 1'b1;
            state   <= LOAD;
          end else begin
            busy    <= 1'b0;
          end
        end
        LOAD: begin
          shreg   <= '0;
          seen    <= '0;
          samples <= '0;
          hit_cnt <= '0;
          match   <= 1'b0;
          if (cfg_bad) begin
            err   <= 1'b1;
            done  <= 1'b1;
            state <= DONE;
          end else begin
            err   <= 1'b0;
            state <= RUN;
          end
        end
        RUN: begin
          shreg   <= shift_nxt;
          samples <= samples_nxt;
          if (hit_now) begin
            match   <= 1'b1;
            hit_cnt <= hit_nxt;
`ifdef SEQ_DET_OVERLAP_EN
            seen    <= seen_nxt;
`else
            // Next occurrence must be built entirely from fresh bits.
            seen    <= LEN_W'(0);
`endif
          end else begin
            match   <= 1'b0;
            seen    <= seen_nxt;
          end
          if (samples_nxt == win_lat) begin
            done  <= 1'b1;
            state <= DONE;
          end else begin
            done  <= 1'b0;
          end
        end
        DONE: begin
          done  <= 1'b0;
          match <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          done  <= 1'b0;
          match <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy    = busy;
  assign bus.match   = match;
  assign bus.done    = done;
  assign bus.err     = err;
  assign bus.hit_cnt = hit_cnt;
endmodule

// File: tb/tb_seq_det_ctrl.sv
// Directed bench for seq_det_ctrl; expected results are hand-computed per scenario.
module tb_seq_det_ctrl;
  logic clk;
  logic rst;
  int   checks;
  int   errors;

  seq_det_ctrl_if #(.PAT_W(8), .CNT_W(8)) bus ();

  seq_det_ctrl #(.PAT_W(8), .CNT_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Edge numbering: E0 = start edge, edge k+1 takes sample k.
  task automatic run_case(input string name, input logic [7:0] pat,
                          input logic [3:0] len, input logic [7:0] win,
                          input logic [255:0] stream, input logic [255:0] exp_m,
                          input int exp_hit, input logic exp_err,
                          input int restart_at);
    int   done_edge;
    logic em;
    done_edge = exp_err ? 1 : int'(win) + 1;
    @(negedge clk);
    bus.start = 1'b1; bus.pattern = pat; bus.pat_len = len; bus.window = win; bus.D = 1'b0;
    @(negedge clk);
    bus.start = 1'b0; bus.pattern = ~pat; bus.pat_len = 4'd1; bus.window = 8'd3;
    for (int n = 1; n <= done_edge + 1; n++) begin
      @(negedge clk);
      em = (!exp_err && n >= 2 && n - 2 < int'(win)) ? exp_m[n-2] : 1'b0;
      checks++;
      if (bus.match !== em) begin
        errors++;
        $display("FAIL %s match edge %0d: got %b expected %b", name, n, bus.match, em);
      end
      checks++;
      if (bus.done !== (n == done_edge)) begin
        errors++;
        $display("FAIL %s done edge %0d: got %b expected %b", name, n, bus.done, n == done_edge);
      end
      checks++;
      if (bus.busy !== (n <= done_edge)) begin
        errors++;
        $display("FAIL %s busy edge %0d: got %b expected %b", name, n, bus.busy, n <= done_edge);
      end
      if (n == done_edge || n == done_edge + 1) begin
        checks++;
        if (bus.hit_cnt !== 8'(exp_hit)) begin
          errors++;
          $display("FAIL %s hit_cnt edge %0d: got %0d expected %0d", name, n, bus.hit_cnt, exp_hit);
        end
        checks++;
        if (bus.err !== exp_err) begin
          errors++;
          $display("FAIL %s err edge %0d: got %b expected %b", name, n, bus.err, exp_err);
        end
      end
      bus.D = (n <= int'(win)) ? stream[n-1] : 1'b0;
      if (n == restart_at) begin
        bus.start = 1'b1; bus.pattern = 8'h00; bus.pat_len = 4'd1; bus.window = 8'd2;
      end else begin
        bus.start = 1'b0;
      end
    end
    bus.start = 1'b0;
    bus.D = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.start = 1'b0; bus.pattern = 8'h00; bus.pat_len = 4'd0; bus.window = 8'd0; bus.D = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({bus.busy, bus.match, bus.done, bus.err, bus.hit_cnt} !== 12'h000) begin
      errors++;
      $display("FAIL reset outputs: got %h expected 000",
               {bus.busy, bus.match, bus.done, bus.err, bus.hit_cnt});
    end
    rst = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL reset idle busy: got %b expected 0", bus.busy);
    end
  endtask

  task automatic test_pattern_1011();
`ifdef SEQ_DET_OVERLAP_EN
    run_case("pat1011", 8'b0000_1011, 4'd4, 8'd12, 256'b1101101, 256'b1001000, 2, 1'b0, 0);
`else
    run_case("pat1011", 8'b0000_1011, 4'd4, 8'd12, 256'b1101101, 256'b0001000, 1, 1'b0, 0);
`endif
  endtask

  task automatic test_single_bit();
    run_case("single_bit", 8'h01, 4'd1, 8'd5, 256'h1F, 256'h1F, 5, 1'b0, 0);
  endtask

  task automatic test_full_length();
    run_case("full_len", 8'b1100_1010, 4'd8, 8'd10, 256'b0101_0011, 256'b1000_0000, 1, 1'b0, 0);
  endtask

  task automatic test_bad_config();
    run_case("len_zero", 8'h01, 4'd0, 8'd10, {256{1'b1}}, 256'h0, 0, 1'b1, 0);
    run_case("len_big", 8'h01, 4'd9, 8'd10, {256{1'b1}}, 256'h0, 0, 1'b1, 0);
    run_case("win_zero", 8'h01, 4'd1, 8'd0, {256{1'b1}}, 256'h0, 0, 1'b1, 0);
  endtask

  task automatic test_restart_ignored();
`ifdef SEQ_DET_OVERLAP_EN
    run_case("restart", 8'b0000_1011, 4'd4, 8'd12, 256'b1101101, 256'b1001000, 2, 1'b0, 5);
`else
    run_case("restart", 8'b0000_1011, 4'd4, 8'd12, 256'b1101101, 256'b0001000, 1, 1'b0, 5);
`endif
  endtask

  task automatic test_reset_mid_run();
    @(negedge clk);
    bus.start = 1'b1; bus.pattern = 8'h01; bus.pat_len = 4'd1; bus.window = 8'd10; bus.D = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (4) @(negedge clk);
    checks++;
    if (bus.hit_cnt !== 8'd3 || bus.match !== 1'b1) begin
      errors++;
      $display("FAIL midrst pre: got hit %0d match %b expected hit 3 match 1", bus.hit_cnt, bus.match);
    end
    rst = 1'b1;
    #1;
    checks++;
    if ({bus.busy, bus.match, bus.done, bus.err, bus.hit_cnt} !== 12'h000) begin
      errors++;
      $display("FAIL midrst async: got %h expected 000",
               {bus.busy, bus.match, bus.done, bus.err, bus.hit_cnt});
    end
    @(negedge clk);
    rst = 1'b0;
    bus.D = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (bus.busy !== 1'b0 || bus.hit_cnt !== 8'd0) begin
      errors++;
      $display("FAIL midrst idle: got busy %b hit %0d expected busy 0 hit 0", bus.busy, bus.hit_cnt);
    end
    run_case("after_rst", 8'h01, 4'd1, 8'd5, 256'h1F, 256'h1F, 5, 1'b0, 0);
  endtask

  task automatic test_full_window();
    run_case("max_window", 8'h01, 4'd1, 8'd255, {256{1'b1}}, {256{1'b1}}, 255, 1'b0, 0);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_pattern_1011();
    test_single_bit();
    test_full_length();
    test_bad_config();
    test_restart_ignored();
    test_reset_mid_run();
    test_full_window();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/seq_det_ctrl.md
SEQ_DET_CTRL -- requirements
Module: seq_det_ctrl

Interface
REQ-001 The block SHALL have parameter PAT_W, default 8, giving the maximum pattern length in bits.
REQ-002 The block SHALL have parameter CNT_W, default 8, giving the width of the window and hit counters.
REQ-003 clk  in  1  single clock; all state changes on its rising edge.
REQ-004 rst  in  1  asynchronous, active-high reset.
REQ-005 start  in  1  request to run one detection window; sampled only in IDLE.
REQ-006 pattern  in  PAT_W  target sequence; pattern[pat_len-1] is the first bit expected, pattern[0] the last.
REQ-007 pat_len  in  $clog2(PAT_W)+1  active pattern length; legal range 1..PAT_W.
REQ-008 window  in  CNT_W  number of D samples to examine; legal range 1..2^CNT_W-1.
REQ-009 D  in  1  serial data bit under test.
REQ-010 busy  out  1  high in every state except IDLE.
REQ-011 match  out  1  one-cycle pulse per detected occurrence.
REQ-012 done  out  1  one-cycle pulse marking the end of a window.
REQ-013 err  out  1  set when the latched configuration was illegal; valid while done is high and held until the next accepted start.
REQ-014 hit_cnt  out  CNT_W  number of matches in the last window; held until the next accepted start.

Function
REQ-015 The FSM SHALL have the states IDLE, LOAD, RUN and DONE.
REQ-016 IDLE with start=1 at an edge: latch pattern, pat_len and window, then go to LOAD; start in any other state is ignored.
REQ-017 LOAD: clear the shift register, the bits-seen counter, the sample counter, hit_cnt and err.
- If the latched pat_len is 0 or greater than PAT_W, or window is 0: set err and go to DONE.
- Otherwise go to RUN.
REQ-018 RUN: at each edge, shift D into the shift register LSB, increment the sample counter, and increment bits-seen, saturating at PAT_W.
REQ-019 Match condition, registered: bits-seen >= pat_len after the shift, and the low pat_len shift-register bits equal pattern[pat_len-1:0]. When it holds, match is high in the following cycle and hit_cnt increments on the same edge.
REQ-020 When the sample counter reaches the latched window value, the FSM SHALL go to DONE; the final sample is still evaluated for a match.
REQ-021 DONE: done is high for exactly one cycle, then the FSM goes to IDLE.
REQ-022 For a legal configuration, start sampled at edge E0 gives LOAD after E0, RUN after E1, D samples at E2..E(window+1), and done high in the cycle after E(window+1).
REQ-023 The inputs pattern, pat_len and window MAY change after the start edge without affecting the run in progress.

Reset
REQ-024 While rst is high, the block SHALL force state to IDLE and busy, match, done, err and hit_cnt to 0, and clear all internal registers; this holds asynchronously and also mid-RUN.
REQ-025 After rst is released, the block SHALL wait for a fresh start.

Configuration
REQ-026 Macro SEQ_DET_OVERLAP_EN:
- Defined: matches may overlap; bits-seen is unaffected by a match.
- Undefined: the edge that registers a match also clears bits-seen, so the next match needs pat_len fresh bits.

Verification
REQ-027 pattern=4'b1011, pat_len=4, window=12, D stream 1,0,1,1,0,1,1,0,0,0,0,0 -> with the macro: hit_cnt=2, match pulses after samples 4 and 7. Without the macro: hit_cnt=1.
REQ-028 pattern=1'b1, pat_len=1, window=5, D held at 1 -> 5 consecutive match pulses, hit_cnt=5, done 7 cycles after the start edge; the result is identical in both configurations.
REQ-029 pat_len=0, window=10 -> LOAD then DONE, err=1, hit_cnt=0, done 2 cycles after start, and no match pulses.
REQ-030 start pulsed again during RUN with a different pattern -> ignored; the first run completes with unchanged hit_cnt.
REQ-031 rst asserted after the 3rd RUN sample -> busy, match, done, hit_cnt and err go to 0 immediately; after release, a new start runs normally from LOAD.
REQ-032 window=2^CNT_W-1, pattern=1'b1, pat_len=1, D held at 1 -> hit_cnt=2^CNT_W-1 with no wrap, and done is asserted once.
